// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types and constants for the AES-128 key schedule controller.
// Used by key_schedule_ctrl (optional zeroize via KEY_SCHED_ZEROIZE_EN) and key_expand_step.
package key_schedule_ctrl_pkg;

  localparam int KEY_W     = 128;
  localparam int WORD_W    = 32;
  localparam int NUM_SLOTS = 11;
  localparam int RD_IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SBOX,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX_LUT [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {SBOX_LUT[w[31:24]], SBOX_LUT[w[23:16]], SBOX_LUT[w[15:8]], SBOX_LUT[w[7:0]]};
  endfunction

  // Rounds past the table contribute no constant.
  function automatic logic [WORD_W-1:0] rcon_word(input logic [RD_IDX_W-1:0] round);
    return (round < 4'd10) ? {RCON[round], 24'h0} : '0;
  endfunction

endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key-expansion round: registered SubWord(RotWord(w3)), then the
// combinational Rcon/XOR chain producing the next round key.
module key_expand_step
  import key_schedule_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_W-1:0]    key_i,
  input  logic [RD_IDX_W-1:0] round_i,
  output logic [KEY_W-1:0]    key_o
);

  logic [WORD_W-1:0] sub_q;
  logic [WORD_W-1:0] w0, w1, w2, w3;

  // Samples every cycle; the controller holds key_i stable through SBOX.
  always_ff @(posedge clk) begin
    if (!rst_n) sub_q <= '0;
    else        sub_q <= sub_word(rot_word(key_i[31:0]));
  end

  // NOTE: combinational chains use blocking '=' so each word sees the one just computed.
  always_comb begin
    w0 = key_i[127:96] ^ sub_q ^ rcon_word(round_i);
    w1 = key_i[95:64]  ^ w0;
    w2 = key_i[63:32]  ^ w1;
    w3 = key_i[31:0]   ^ w2;
    key_o = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands one cipher key into NUM_ROUNDS+1 round-key slots.
// Optional KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes all state in one cycle.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_SLOTS - 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                key_valid,
  input  logic [KEY_W-1:0]    key_in,
  output logic                key_ready,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [RD_IDX_W-1:0] rd_round,
  output logic [KEY_W-1:0]    rd_key
);

  localparam int NSLOT = NUM_ROUNDS + 1;

  state_e              state_q;
  logic [RD_IDX_W-1:0] round_q;
  logic [RD_IDX_W-1:0] wr_idx;
  logic [KEY_W-1:0]    cur_key_q;
  logic [KEY_W-1:0]    slots_q [NSLOT];
  logic [KEY_W-1:0]    step_key;
  logic [KEY_W-1:0]    rd_key_q;
  logic                key_ready_q, busy_q, done_q, keys_valid_q;
  logic                clear;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign clear = !rst_n || zeroize;
`else
  assign clear = !rst_n;
`endif

  assign wr_idx = round_q + 1'b1;

  key_expand_step u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (cur_key_q),
    .round_i (round_q),
    .key_o   (step_key)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      cur_key_q    <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      // NOTE: key storage is reset explicitly so no key material survives a reset or wipe.
      for (int i = 0; i < NSLOT; i++) slots_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid && key_ready_q) begin
            slots_q[0]   <= key_in;
            cur_key_q    <= key_in;
            round_q      <= '0;
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_SBOX;
          end
        end
        ST_SBOX: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          slots_q[wr_idx] <= step_key;
          cur_key_q       <= step_key;
          if (round_q == RD_IDX_W'(NUM_ROUNDS - 1)) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            round_q <= wr_idx;
            state_q <= ST_SBOX;
          end
        end
        ST_DONE: begin
          done_q      <= 1'b0;
          key_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read port reflects live slot contents, including mid-expansion.
  always_ff @(posedge clk) begin
    if (clear)                        rd_key_q <= '0;
    else if (int'(rd_round) < NSLOT)  rd_key_q <= slots_q[rd_round];
    else                              rd_key_q <= '0;
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a GF(2^8)-arithmetic key-expansion model.
// Exercises the zeroize input when KEY_SCHED_ZEROIZE_EN is defined.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rd_round = '0;
  logic         key_ready, busy, done, keys_valid;
  logic [127:0] rd_key;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] ref_slots [11];

  always #5 clk = ~clk;

  key_schedule_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_round   (rd_round),
    .rd_key     (rd_key)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] xb  = 8'(x);
      if (x == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w0, w1, w2, w3, t;
    ref_slots[0] = key;
    for (int r = 0; r < 10; r++) begin
      {w0, w1, w2, w3} = ref_slots[r];
      t = {w3[23:0], w3[31:24]};
      t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
      t = t ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      ref_slots[r+1] = {w0, w1, w2, w3};
      rc = xtime(rc);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic read_slot(input int idx, output logic [127:0] val);
    rd_round = 4'(idx);
    tick();
    val = rd_key;
  endtask

  task automatic check_slots(input string tag, input logic zero);
    logic [127:0] v;
    for (int i = 0; i < 11; i++) begin
      read_slot(i, v);
      check($sformatf("%s slot%0d", tag, i), v, zero ? 128'h0 : ref_slots[i]);
    end
  endtask

  // Presents key for one handshake cycle T; returns in cycle T+1.
  task automatic accept(input string tag, input logic [127:0] key);
    key_in = key;
    key_valid = 1'b1;
    check({tag, " key_ready@T"}, 128'(key_ready), 128'h1);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic run_expand(input string tag, input logic [127:0] key);
    int k = 1;
    accept(tag, key);
    check({tag, " busy@T+1"}, 128'(busy), 128'h1);
    while (!done && k < 40) begin
      tick();
      k++;
    end
    check({tag, " done latency"}, 128'(k), 128'd21);
    check({tag, " keys_valid@done"}, 128'(keys_valid), 128'h1);
    tick();
    check({tag, " done single pulse"}, 128'(done), 128'h0);
    model_expand(key);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] v, key_a, key_b;
    logic         kv [64];
    logic         dn [64];
    logic         kr [64];
    int           cnt;

    build_sbox();

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst key_ready", 128'(key_ready), 128'h1);
    check("rst busy", 128'(busy), 128'h0);
    check("rst done", 128'(done), 128'h0);
    check("rst keys_valid", 128'(keys_valid), 128'h0);
    check("rst rd_key", rd_key, 128'h0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 vector
    run_expand("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_slot(1, v);
    check("fips slot1 const", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_slot(10, v);
    check("fips slot10 const", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_slot(15, v);
    check("fips rd_round15", v, 128'h0);
    check_slots("fips", 1'b0);

    // All-zero key
    run_expand("zero", 128'h0);
    read_slot(1, v);
    check("zero slot1 const", v, 128'h62636363626363636263636362636363);
    read_slot(10, v);
    check("zero slot10 const", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Random keys
    for (int n = 0; n < 3; n++) begin
      run_expand($sformatf("rand%0d", n), {$urandom, $urandom, $urandom, $urandom});
      check_slots($sformatf("rand%0d", n), 1'b0);
    end

    // key_valid held through busy/DONE with a second key waiting
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    key_in = key_a;
    key_valid = 1'b1;
    check("b2b key_ready@T", 128'(key_ready), 128'h1);
    tick();
    key_in = key_b;
    rd_round = 4'd0;
    for (int k = 1; k <= 44; k++) begin
      kv[k] = keys_valid;
      dn[k] = done;
      kr[k] = key_ready;
      if (k == 23) key_valid = 1'b0;
      if (k == 20) check("b2b slot0 during busy", rd_key, key_a);
      tick();
    end
    check("b2b done@T+21", 128'(dn[21]), 128'h1);
    check("b2b keys_valid@T+21", 128'(kv[21]), 128'h1);
    check("b2b keys_valid@T+22", 128'(kv[22]), 128'h1);
    check("b2b key_ready@T+22", 128'(kr[22]), 128'h1);
    cnt = 0;
    for (int k = 23; k <= 42; k++) cnt += int'(kv[k]);
    check("b2b keys_valid high T+23..42", 128'(cnt), 128'd0);
    check("b2b keys_valid@T+43", 128'(kv[43]), 128'h1);
    check("b2b done@T+43", 128'(dn[43]), 128'h1);
    cnt = 0;
    for (int k = 1; k <= 44; k++) cnt += int'(dn[k]);
    check("b2b done pulses", 128'(cnt), 128'd2);
    model_expand(key_b);
    check_slots("b2b keyB", 1'b0);

    // Reset mid-expansion at T+9
    accept("midrst", {$urandom, $urandom, $urandom, $urandom});
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst keys_valid", 128'(keys_valid), 128'h0);
    check("midrst key_ready", 128'(key_ready), 128'h1);
    check("midrst busy", 128'(busy), 128'h0);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      cnt += int'(done);
      tick();
    end
    check("midrst no done", 128'(cnt), 128'd0);
    check_slots("midrst cleared", 1'b1);
    key_a = {$urandom, $urandom, $urandom, $urandom};
    run_expand("postrst", key_a);
    check_slots("postrst", 1'b0);

`ifdef KEY_SCHED_ZEROIZE_EN
    // Zeroize in CAPTURE of round 5 (cycle T+12)
    accept("zeroize", {$urandom, $urandom, $urandom, $urandom});
    repeat (11) tick();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zeroize key_ready", 128'(key_ready), 128'h1);
    check("zeroize busy", 128'(busy), 128'h0);
    check("zeroize keys_valid", 128'(keys_valid), 128'h0);
    check("zeroize rd_key", rd_key, 128'h0);
    check_slots("zeroize", 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
